pagerank_partition_scheduler: RTL and testbench
===============================================

Name: pagerank_partition_scheduler

Overview:
Sequences the serial DMP pagerank datapath across iterations. Hands graph partitions to NUM_HW_THREADS hardware threads using round-robin among idle threads. Collects per-thread done/converged reports and pulses a rank-buffer swap at each iteration boundary. Terminates on global convergence or at the iteration limit, and drives pagerank_complete.

Parameters:
NUM_HW_THREADS, 7, number of worker threads.
NUM_PARTITIONS, 7, maximum partitions per iteration.
ITER_W, 8, width of the iteration counter and the iteration limit.
Derived: TID_W = max(1, clog2(NUM_HW_THREADS)); PID_W = clog2(NUM_PARTITIONS+1).

Ports:
clock  in  1  system clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
start  in  1  begins a run; sampled only in IDLE or DONE.
num_partitions_cfg  in  PID_W  partitions per iteration; latched on start.
max_iter_cfg  in  ITER_W  iteration limit; latched on start.
thread_done  in  NUM_HW_THREADS  per-thread 1-cycle pulse: partition finished.
thread_converged  in  NUM_HW_THREADS  per-thread flag, valid with thread_done: partition delta below threshold.
dispatch_valid  out  1  1-cycle pulse: assign a partition.
dispatch_thread  out  TID_W  target thread of the dispatch.
dispatch_partition  out  PID_W  partition index of the dispatch.
swap_buffers  out  1  1-cycle pulse at the end of each iteration.
iteration  out  ITER_W  count of completed iterations.
busy  out  1  high in every state except IDLE and DONE.
pagerank_complete  out  1  held high in DONE.
converged  out  1  valid in DONE: 1 if the final iteration converged.
protocol_error  out  1  sticky: thread_done seen for a thread not busy.

Behaviour:
- Reset (async assert): state IDLE, internal busy mask 0, rr_ptr 0, next_part 0; all outputs 0. Reset mid-run abandons the run, with no swap and no complete.
- Latching on start:
  - num_partitions_cfg > NUM_PARTITIONS is clamped to NUM_PARTITIONS.
  - max_iter_cfg 0 is treated as 1.
  - iteration cleared; conv_all set to 1; protocol_error cleared.
- Outputs are decoded from registered state only; there is no combinational input-to-output path.
- IDLE:
  - start with nparts 0 → DONE; converged = 1, iteration = 0.
  - start with nparts > 0 → DISPATCH.
- DISPATCH:
  - Each cycle where next_part < nparts and a non-busy thread exists: dispatch_valid = 1.
  - dispatch_thread = first non-busy thread searching upward from rr_ptr, wrapping modulo NUM_HW_THREADS.
  - dispatch_partition = next_part.
  - On the edge: set busy[thread], next_part++, rr_ptr = thread+1 (wraps).
  - A dispatch is accepted unconditionally; threads have no ready signal.
  - If all threads are busy: no dispatch, stay in DISPATCH.
  - After the edge where next_part reaches nparts → DRAIN.
- thread_done[i], processed in every state:
  - Clears busy[i] on the edge; conv_all &= thread_converged[i].
  - Multiple simultaneous dones are all processed.
  - A thread freed at edge t is dispatchable in the cycle after edge t, never in the same cycle as its done pulse.
  - Done for a non-busy thread: ignored for state, conv_all unaffected, protocol_error set.
- DRAIN: when the busy mask is 0 → SWAP.
- SWAP (one cycle):
  - swap_buffers = 1; iteration++ on exit.
  - If conv_all = 1, or iteration+1 ≥ max_iter → DONE with converged = conv_all.
  - Otherwise next_part = 0, conv_all = 1 → DISPATCH.
- DONE:
  - pagerank_complete held at 1; iteration and converged held.
  - start → same latching as from IDLE, and a new run begins.
- start outside IDLE/DONE is ignored.
- rr_ptr persists across iterations; it is cleared only by reset.

Test Plan:
- Defaults; start with nparts 7, max_iter 10. Each thread pulses done with converged = 1 five cycles after dispatch → dispatches in 7 consecutive cycles, threads 0..6 paired with partitions 0..6. Then one swap_buffers pulse, pagerank_complete = 1, iteration = 1, converged = 1.
- NUM_HW_THREADS = 3; nparts 7; every done 4 cycles after dispatch, converged = 1 → dispatches (t0,p0), (t1,p1), (t2,p2), stall, then p3..p6 to threads in done order. No dispatch occurs in a done cycle; exactly one swap; iteration = 1.
- nparts 3, max_iter 4, thread_converged always 0 → 4 swap pulses, 12 dispatches total, complete with iteration = 4, converged = 0. Second iteration begins at thread 3 (rr_ptr persistence).
- Iteration 1 with one partition not converged, iteration 2 all converged, max_iter 10 → 2 swaps, iteration = 2, converged = 1.
- thread_done[5] pulsed while thread 5 is idle → protocol_error = 1 and sticky; scheduling is unaffected. The next start clears it.
- Two edge cases:
  - reset_n low for 1 ns during DRAIN → all outputs 0 immediately. A following start runs normally from iteration 0.
  - start with nparts 0 → pagerank_complete on the next cycle, iteration = 0, no dispatch or swap.

Source files
------------

// File: rtl/pagerank_partition_scheduler.sv
// Iteration sequencer for the pagerank datapath: round-robin partition dispatch to idle
// hardware threads, per-iteration buffer swap, and convergence / iteration-limit termination.
module prs_thread_slot (
  input  logic clock,
  input  logic reset_n,
  input  logic set,
  input  logic done,
  input  logic conv_in,
  output logic busy,
  output logic done_bad,
  output logic conv_ok
);
  // A thread cannot be dispatched while busy, so set and a legal done never collide.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  busy <= 1'b0;
    else if (set)  busy <= 1'b1;
    else if (done) busy <= 1'b0;
  end

  assign done_bad = done & ~busy;
  assign conv_ok  = ~(done & busy) | conv_in;
endmodule

module pagerank_partition_scheduler #(
  parameter  int NUM_HW_THREADS = 7,
  parameter  int NUM_PARTITIONS = 7,
  parameter  int ITER_W         = 8,
  localparam int TID_W = (NUM_HW_THREADS > 1) ? $clog2(NUM_HW_THREADS) : 1,
  localparam int PID_W = $clog2(NUM_PARTITIONS + 1)
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [PID_W-1:0]          num_partitions_cfg,
  input  logic [ITER_W-1:0]         max_iter_cfg,
  input  logic [NUM_HW_THREADS-1:0] thread_done,
  input  logic [NUM_HW_THREADS-1:0] thread_converged,
  output logic                      dispatch_valid,
  output logic [TID_W-1:0]          dispatch_thread,
  output logic [PID_W-1:0]          dispatch_partition,
  output logic                      swap_buffers,
  output logic [ITER_W-1:0]         iteration,
  output logic                      busy,
  output logic                      pagerank_complete,
  output logic                      converged,
  output logic                      protocol_error
);
  typedef enum logic [2:0] {S_IDLE, S_DISPATCH, S_DRAIN, S_SWAP, S_DONE} state_t;

  state_t                    state;
  logic [PID_W-1:0]          nparts, next_part, nparts_in;
  logic [ITER_W-1:0]         max_iter, max_iter_in;
  logic [TID_W-1:0]          rr_ptr, pick_tid;
  logic                      conv_all, pick_found, disp_go;
  logic [NUM_HW_THREADS-1:0] busy_mask, set_vec, done_bad, conv_ok;
  int                        idx;

  prs_thread_slot u_slot [NUM_HW_THREADS-1:0] (
    .clock    (clock),
    .reset_n  (reset_n),
    .set      (set_vec),
    .done     (thread_done),
    .conv_in  (thread_converged),
    .busy     (busy_mask),
    .done_bad (done_bad),
    .conv_ok  (conv_ok)
  );

  assign nparts_in   = (num_partitions_cfg > PID_W'(NUM_PARTITIONS)) ? PID_W'(NUM_PARTITIONS)
                                                                      : num_partitions_cfg;
  assign max_iter_in = (max_iter_cfg == '0) ? ITER_W'(1) : max_iter_cfg;

  // First idle thread at or after rr_ptr, wrapping; busy_mask is registered so a thread
  // whose done pulse is in flight is still seen busy this cycle.
  always_comb begin
    pick_found = 1'b0;
    pick_tid   = '0;
    idx        = 0;
    for (int k = 0; k < NUM_HW_THREADS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_HW_THREADS) idx = idx - NUM_HW_THREADS;
      if (!pick_found && !busy_mask[idx]) begin
        pick_found = 1'b1;
        pick_tid   = TID_W'(idx);
      end
    end
  end

  assign disp_go = (state == S_DISPATCH) && (next_part < nparts) && pick_found;

  always_comb begin
    set_vec = '0;
    if (disp_go) set_vec[pick_tid] = 1'b1;
  end

  assign dispatch_valid     = disp_go;
  assign dispatch_thread    = disp_go ? pick_tid : '0;
  assign dispatch_partition = disp_go ? next_part : '0;
  assign swap_buffers       = (state == S_SWAP);
  assign busy               = (state != S_IDLE) && (state != S_DONE);
  assign pagerank_complete  = (state == S_DONE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      nparts         <= '0;
      max_iter       <= '0;
      next_part      <= '0;
      rr_ptr         <= '0;
      conv_all       <= 1'b0;
      iteration      <= '0;
      converged      <= 1'b0;
      protocol_error <= 1'b0;
    end else begin
      if (!(&conv_ok))  conv_all       <= 1'b0;
      if (|done_bad)    protocol_error <= 1'b1;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            nparts         <= nparts_in;
            max_iter       <= max_iter_in;
            next_part      <= '0;
            iteration      <= '0;
            conv_all       <= 1'b1;
            protocol_error <= 1'b0;
            converged      <= (nparts_in == '0);
            state          <= (nparts_in == '0) ? S_DONE : S_DISPATCH;
          end
        end
        S_DISPATCH: begin
          if (disp_go) begin
            next_part <= next_part + PID_W'(1);
            rr_ptr    <= (pick_tid == TID_W'(NUM_HW_THREADS - 1)) ? '0 : pick_tid + TID_W'(1);
            if (next_part + PID_W'(1) == nparts) state <= S_DRAIN;
          end
        end
        S_DRAIN: if (busy_mask == '0) state <= S_SWAP;
        S_SWAP: begin
          iteration <= iteration + ITER_W'(1);
          if (conv_all || ({1'b0, iteration} + (ITER_W+1)'(1) >= {1'b0, max_iter})) begin
            converged <= conv_all;
            state     <= S_DONE;
          end else begin
            next_part <= '0;
            conv_all  <= 1'b1;
            state     <= S_DISPATCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pagerank_partition_scheduler.sv
// Bench: a 7-thread and a 3-thread scheduler, each served by a fixed-latency thread model;
// expected (thread, partition) pairs are queued up front and popped as dispatches appear.
module tb_pagerank_partition_scheduler;
  logic clock = 1'b0, reset_n = 1'b0;
  always #5 clock = ~clock;

  int n_chk = 0, n_pass = 0, cyc = 0;
  always @(posedge clock) cyc++;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // ---------------- 7-thread instance ----------------
  logic       start = 1'b0;
  logic [2:0] np_cfg = '0;
  logic [7:0] mi_cfg = '0;
  logic [6:0] td = '0, tc = '0;
  logic       dv, swap, bsy, cmpl, conv, perr;
  logic [2:0] dt, dp;
  logic [7:0] iter;

  pagerank_partition_scheduler u_dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .num_partitions_cfg(np_cfg), .max_iter_cfg(mi_cfg),
    .thread_done(td), .thread_converged(tc),
    .dispatch_valid(dv), .dispatch_thread(dt), .dispatch_partition(dp),
    .swap_buffers(swap), .iteration(iter), .busy(bsy),
    .pagerank_complete(cmpl), .converged(conv), .protocol_error(perr));

  int cnt1 [7], part1 [7];
  int mode1 = 0, lat1 = 5, ndisp1 = 0, nswap1 = 0, bd1 = 0, bs1 = 0, inj_req = 0, inj_done = 0;
  int q1 [$], dcyc1 [$];

  always @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 7; i++) cnt1[i] = 0;
      td = '0;
    end else begin
      for (int i = 0; i < 7; i++) begin
        td[i] = 1'b0;
        if (cnt1[i] > 0) begin
          cnt1[i]--;
          if (cnt1[i] == 0) begin
            td[i] = 1'b1;
            tc[i] = (mode1 == 1) ? 1'b0 :
                    (mode1 == 2 && part1[i] == 0 && nswap1 == bs1) ? 1'b0 : 1'b1;
          end
        end
      end
      if (inj_done != inj_req) begin
        td[5] = 1'b1; tc[5] = 1'b0; inj_done = inj_req;
      end
      if (swap) nswap1++;
      if (dv) begin
        if (q1.size() == 0) chk("disp1_extra", int'({dt, dp}), -1);
        else chk("disp1_pair", int'({dt, dp}), q1.pop_front());
        chk("disp1_not_in_done_cycle", int'(td[dt]), 0);
        cnt1[dt] = lat1; part1[dt] = int'(dp);
        dcyc1.push_back(cyc);
        ndisp1++;
      end
    end
  end

  task automatic go1(input int np, input int mi);
    @(negedge clock);
    bd1 = ndisp1; bs1 = nswap1;
    np_cfg = 3'(np); mi_cfg = 8'(mi); start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait1(input string tag, input int limit);
    int c = 0;
    while (!cmpl && c < limit) begin @(negedge clock); c++; end
    chk({tag, "_complete"}, int'(cmpl), 1);
  endtask

  task automatic res1(input string tag, input int it, input int cv, input int ns, input int nd);
    chk({tag, "_iteration"}, int'(iter), it);
    chk({tag, "_converged"}, int'(conv), cv);
    chk({tag, "_swaps"}, nswap1 - bs1, ns);
    chk({tag, "_dispatches"}, ndisp1 - bd1, nd);
    chk({tag, "_queue_left"}, q1.size(), 0);
    chk({tag, "_busy_low"}, int'(bsy), 0);
  endtask

  // ---------------- 3-thread instance ----------------
  logic       start2 = 1'b0;
  logic [2:0] np2 = '0;
  logic [7:0] mi2 = '0;
  logic [2:0] td2 = '0, tc2 = '0;
  logic       dv2, swap2, bsy2, cmpl2, conv2, perr2;
  logic [1:0] dt2;
  logic [2:0] dp2;
  logic [7:0] iter2;

  pagerank_partition_scheduler #(.NUM_HW_THREADS(3)) u_dut3 (
    .clock(clock), .reset_n(reset_n), .start(start2),
    .num_partitions_cfg(np2), .max_iter_cfg(mi2),
    .thread_done(td2), .thread_converged(tc2),
    .dispatch_valid(dv2), .dispatch_thread(dt2), .dispatch_partition(dp2),
    .swap_buffers(swap2), .iteration(iter2), .busy(bsy2),
    .pagerank_complete(cmpl2), .converged(conv2), .protocol_error(perr2));

  int cnt2 [3];
  int mode2 = 0, ndisp2 = 0, nswap2 = 0, bd2 = 0, bs2 = 0;
  int q2 [$], dcyc2 [$];

  always @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) cnt2[i] = 0;
      td2 = '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        td2[i] = 1'b0;
        if (cnt2[i] > 0) begin
          cnt2[i]--;
          if (cnt2[i] == 0) begin td2[i] = 1'b1; tc2[i] = (mode2 == 0); end
        end
      end
      if (swap2) nswap2++;
      if (dv2) begin
        if (q2.size() == 0) chk("disp3_extra", int'({dt2, dp2}), -1);
        else chk("disp3_pair", int'({dt2, dp2}), q2.pop_front());
        chk("disp3_not_in_done_cycle", int'(td2[dt2]), 0);
        cnt2[dt2] = 4;
        dcyc2.push_back(cyc);
        ndisp2++;
      end
    end
  end

  task automatic go2(input int np, input int mi);
    @(negedge clock);
    bd2 = ndisp2; bs2 = nswap2;
    np2 = 3'(np); mi2 = 8'(mi); start2 = 1'b1;
    @(negedge clock);
    start2 = 1'b0;
  endtask

  task automatic fin2(input string tag, input int it, input int cv, input int ns, input int nd);
    int c = 0;
    while (!cmpl2 && c < 400) begin @(negedge clock); c++; end
    chk({tag, "_complete"}, int'(cmpl2), 1);
    chk({tag, "_iteration"}, int'(iter2), it);
    chk({tag, "_converged"}, int'(conv2), cv);
    chk({tag, "_swaps"}, nswap2 - bs2, ns);
    chk({tag, "_dispatches"}, ndisp2 - bd2, nd);
    chk({tag, "_queue_left"}, q2.size(), 0);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    chk("rst_busy", int'(bsy), 0);
    chk("rst_complete", int'(cmpl), 0);
    chk("rst_iteration", int'(iter), 0);
    chk("rst_dispatch", int'(dv), 0);
    chk("rst_perr", int'(perr), 0);
    reset_n = 1'b1;

    // 3 threads, 7 partitions: three back-to-back, stall, then refill in done order
    for (int p = 0; p < 7; p++) q2.push_back((p % 3) * 8 + p);
    go2(7, 10);
    fin2("thr3", 1, 1, 1, 7);
    chk("thr3_first_three_back_to_back", dcyc2[bd2 + 2] - dcyc2[bd2], 2);
    chk("thr3_stall_gap", dcyc2[bd2 + 3] - dcyc2[bd2 + 2], 3);
    chk("thr3_last_gap", dcyc2[bd2 + 6] - dcyc2[bd2 + 5], 3);

    // max_iter 0 acts as 1; rr_ptr continues at thread 1
    mode2 = 1;
    q2.push_back(1 * 8 + 0); q2.push_back(2 * 8 + 1);
    go2(2, 0);
    fin2("maxiter0", 1, 0, 1, 2);

    // 7 partitions on 7 threads, single converged iteration
    for (int p = 0; p < 7; p++) q1.push_back(p * 8 + p);
    go1(7, 10);
    wait1("full7", 300);
    res1("full7", 1, 1, 1, 7);
    chk("full7_consecutive", dcyc1[bd1 + 6] - dcyc1[bd1], 6);

    // never converges: runs to the iteration limit, rr_ptr carries across iterations
    mode1 = 1;
    for (int it = 0; it < 4; it++)
      for (int p = 0; p < 3; p++) q1.push_back(((it * 3 + p) % 7) * 8 + p);
    go1(3, 4);
    wait1("limit", 600);
    res1("limit", 4, 0, 4, 12);

    // first iteration has one unconverged partition, second converges
    mode1 = 2;
    q1.push_back(5 * 8 + 0); q1.push_back(6 * 8 + 1);
    q1.push_back(0 * 8 + 0); q1.push_back(1 * 8 + 1);
    go1(2, 10);
    wait1("conv2", 300);
    res1("conv2", 2, 1, 2, 4);

    // stray done on idle thread 5 (reporting not-converged) must only raise protocol_error
    mode1 = 0;
    q1.push_back(2 * 8 + 0); q1.push_back(3 * 8 + 1);
    go1(2, 1);
    inj_req++;
    wait1("perr", 300);
    res1("perr", 1, 1, 1, 2);
    chk("perr_set", int'(perr), 1);
    repeat (3) @(negedge clock);
    chk("perr_sticky", int'(perr), 1);

    // new run clears protocol_error; reset during DRAIN abandons it
    lat1 = 20;
    for (int p = 0; p < 7; p++) q1.push_back(((4 + p) % 7) * 8 + p);
    go1(7, 10);
    chk("perr_cleared_by_start", int'(perr), 0);
    for (int c = 0; c < 50 && (ndisp1 - bd1) < 7; c++) @(negedge clock);
    chk("drain_dispatches", ndisp1 - bd1, 7);
    @(negedge clock);
    chk("drain_busy", int'(bsy), 1);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("midrun_rst_busy", int'(bsy), 0);
    chk("midrun_rst_swap", int'(swap), 0);
    chk("midrun_rst_complete", int'(cmpl), 0);
    chk("midrun_rst_dispatch", int'(dv), 0);
    chk("midrun_rst_converged", int'(conv), 0);
    reset_n = 1'b1;
    lat1 = 5;

    // zero partitions from IDLE: complete on the next cycle, nothing dispatched
    go1(0, 5);
    chk("np0_complete_next_cycle", int'(cmpl), 1);
    repeat (3) @(negedge clock);
    res1("np0", 0, 1, 0, 0);

    // normal run after reset; rr_ptr back at 0
    for (int p = 0; p < 7; p++) q1.push_back(p * 8 + p);
    go1(7, 10);
    wait1("post_rst", 300);
    res1("post_rst", 1, 1, 1, 7);
    chk("post_rst_perr", int'(perr), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
